// File: rtl/map_loader.sv
// Loads one 81-cell puzzle from a synchronous ROM into shadow registers and publishes
// map and visibility mask in a single cycle. Define MAP_VALIDATE_EN to reject bad puzzles.
module map_loader #(
   parameter int NUM_PUZZLES = 4,
   parameter int ADDR_W      = 9,
   localparam int PID_W      = (NUM_PUZZLES > 1) ? $clog2(NUM_PUZZLES) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_start,
   input  logic              difficulty,
   output logic              rom_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [5:0]        rom_data,
   output logic [323:0]      selected_map,
   output logic [80:0]       selected_visibility,
   output logic [PID_W-1:0]  puzzle_id,
   output logic              busy,
   output logic              done,
   output logic              load_error
);

   localparam int CELLS = 81;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, PUBLISH} state_t;

   state_t             state;
   logic [PID_W-1:0]   sel_cnt;
   logic               diff_r;
   logic [6:0]         k;
   logic               cap_valid;
   logic [6:0]         cap_idx;
   logic [323:0]       shadow_map;
   logic [80:0]        shadow_vis;
`ifdef MAP_VALIDATE_EN
   logic               bad;
`else
   assign load_error = 1'b0;
`endif

   // Free-running puzzle selector; its value at the request edge picks the puzzle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         sel_cnt <= '0;
      else if (sel_cnt == PID_W'(NUM_PUZZLES - 1))
         sel_cnt <= '0;
      else
         sel_cnt <= sel_cnt + 1'b1;
   end

   // NOTE: all state here is sequential, so every assignment is non-blocking; the
   // capture pipeline and the FSM then see each other's values from before the edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state               <= IDLE;
         diff_r              <= 1'b0;
         k                   <= '0;
         cap_valid           <= 1'b0;
         cap_idx             <= '0;
         // NOTE: the shadows are plain flops, not a RAM, so clearing them on reset is
         // cheap and guarantees an aborted load can never leak into a later publish.
         shadow_map          <= '0;
         shadow_vis          <= '0;
         rom_en              <= 1'b0;
         rom_addr            <= '0;
         selected_map        <= '0;
         selected_visibility <= '0;
         puzzle_id           <= '0;
         busy                <= 1'b0;
         done                <= 1'b0;
`ifdef MAP_VALIDATE_EN
         bad                 <= 1'b0;
         load_error          <= 1'b0;
`endif
      end else begin
         done      <= 1'b0;
`ifdef MAP_VALIDATE_EN
         load_error <= 1'b0;
`endif
         // ROM answers one cycle after the address, so the cell index trails rom_en by one.
         cap_valid <= rom_en;
         cap_idx   <= k;
         if (cap_valid) begin
            shadow_map[{cap_idx, 2'b00} +: 4] <= rom_data[3:0];
            shadow_vis[cap_idx]               <= diff_r ? rom_data[4] : rom_data[5];
`ifdef MAP_VALIDATE_EN
            if (rom_data[3:0] == 4'd0 || rom_data[3:0] > 4'd9)
               bad <= 1'b1;
`endif
         end

         unique case (state)
            IDLE: begin
               if (load_start) begin
                  puzzle_id           <= sel_cnt;
                  diff_r              <= difficulty;
                  selected_map        <= '0;
                  selected_visibility <= '0;
                  shadow_map          <= '0;
                  shadow_vis          <= '0;
`ifdef MAP_VALIDATE_EN
                  bad                 <= 1'b0;
`endif
                  busy                <= 1'b1;
                  rom_en              <= 1'b1;
                  rom_addr            <= ADDR_W'(int'(sel_cnt) * CELLS);
                  k                   <= '0;
                  state               <= FETCH;
               end
            end
            FETCH: begin
               if (k == 7'(CELLS - 1)) begin
                  rom_en <= 1'b0;
                  state  <= DRAIN;
               end else begin
                  k        <= k + 1'b1;
                  rom_addr <= rom_addr + 1'b1;
               end
            end
            DRAIN: begin
               state <= PUBLISH;
            end
            PUBLISH: begin
               busy  <= 1'b0;
               state <= IDLE;
`ifdef MAP_VALIDATE_EN
               if (bad || shadow_vis == '0) begin
                  load_error <= 1'b1;
               end else begin
                  selected_map        <= shadow_map;
                  selected_visibility <= shadow_vis;
                  done                <= 1'b1;
               end
`else
               selected_map        <= shadow_map;
               selected_visibility <= shadow_vis;
               done                <= 1'b1;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_map_loader.sv
// Scoreboard bench for map_loader: a behavioural ROM, expected puzzles queued at request
// time and compared when done/load_error pulses. Honours MAP_VALIDATE_EN like the design.
module tb_map_loader;

   localparam int NP    = 4;
   localparam int AW    = 9;
   localparam int CELLS = 81;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          load_start = 1'b0;
   logic          difficulty = 1'b0;
   logic          rom_en;
   logic [AW-1:0] rom_addr;
   logic [5:0]    rom_data = '0;
   logic [323:0]  selected_map;
   logic [80:0]   selected_visibility;
   logic [1:0]    puzzle_id;
   logic          busy;
   logic          done;
   logic          load_error;

   map_loader #(.NUM_PUZZLES(NP), .ADDR_W(AW)) dut (
      .clk                 (clk),
      .reset               (reset),
      .load_start          (load_start),
      .difficulty          (difficulty),
      .rom_en              (rom_en),
      .rom_addr            (rom_addr),
      .rom_data            (rom_data),
      .selected_map        (selected_map),
      .selected_visibility (selected_visibility),
      .puzzle_id           (puzzle_id),
      .busy                (busy),
      .done                (done),
      .load_error          (load_error)
   );

   always #5 clk = ~clk;

   logic [5:0] rom [0:511];
   always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

   // Reference model of the free-running selector.
   logic [1:0] mdl_sel;
   always @(posedge clk or negedge reset)
      if (!reset) mdl_sel <= '0;
      else        mdl_sel <= mdl_sel + 2'd1;

   typedef struct {
      logic         err;
      logic [1:0]   pid;
      logic [323:0] map;
      logic [80:0]  vis;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string tag, input logic [323:0] obs, input logic [323:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic exp_t build_exp(input logic [1:0] pid, input logic diff);
      exp_t       e;
      logic [5:0] w;
`ifdef MAP_VALIDATE_EN
      logic       bad;
      bad = 1'b0;
`endif
      e.pid = pid;
      e.err = 1'b0;
      e.map = '0;
      e.vis = '0;
      for (int j = 0; j < CELLS; j++) begin
         w = rom[9'(int'(pid) * CELLS + j)];
         e.map[4*j +: 4] = w[3:0];
         e.vis[j]        = diff ? w[4] : w[5];
`ifdef MAP_VALIDATE_EN
         if (w[3:0] == 4'd0 || w[3:0] > 4'd9) bad = 1'b1;
`endif
      end
`ifdef MAP_VALIDATE_EN
      if (e.vis == '0) bad = 1'b1;
      e.err = bad;
      if (bad) begin
         e.map = '0;
         e.vis = '0;
      end
`endif
      return e;
   endfunction

   // Issues one request (optionally waiting for a given selector value) and checks every
   // cycle of the load. Must be called at a negedge.
   task automatic run_load(input int want, input logic diff, input int toggle_at,
                           input int restart_at, input int abort_at, input bit chain);
      exp_t e;
      exp_t g;
      int   base;
      int   lim;
      bit   got;
      got = 1'b0;
      if (want >= 0) begin
         for (int i = 0; i < 8 && int'(mdl_sel) != want; i++) @(negedge clk);
         check("sel_sync", 324'(mdl_sel), 324'(want));
      end
      e = build_exp(mdl_sel, diff);
      sb.push_back(e);
      base = int'(mdl_sel) * CELLS;
      load_start = 1'b1;
      difficulty = diff;
      lim = chain ? 84 : 90;
      for (int c = 1; c <= lim; c++) begin
         @(negedge clk);
         load_start = (c == restart_at);
         if (c == toggle_at) difficulty = ~diff;
         if (c == abort_at) begin
            reset = 1'b0;
            #1;
            check("rst_busy", 324'(busy), 324'(0));
            check("rst_rom_en", 324'(rom_en), 324'(0));
            check("rst_map", selected_map, 324'(0));
            check("rst_vis", 324'(selected_visibility), 324'(0));
            check("rst_pid", 324'(puzzle_id), 324'(0));
            void'(sb.pop_back());
            @(negedge clk);
            check("rst_hold_busy", 324'(busy), 324'(0));
            check("rst_hold_done", 324'(done), 324'(0));
            @(negedge clk);
            reset = 1'b1;
            return;
         end
         check("rom_en", 324'(rom_en), 324'(c <= 81));
         if (c <= 81) check("rom_addr", 324'(rom_addr), 324'(base + c - 1));
         check("busy", 324'(busy), 324'(c <= 83));
         if (c == 1) begin
            check("clear_map", selected_map, 324'(0));
            check("clear_vis", 324'(selected_visibility), 324'(0));
         end
         if (done || load_error) begin
            if (sb.size() == 0) begin
               check("unexpected_pulse", 324'(c), 324'(0));
            end else begin
               g = sb.pop_front();
               got = 1'b1;
               check("pulse_cycle", 324'(c), 324'(84));
               check("load_error", 324'(load_error), 324'(g.err));
               check("done", 324'(done), 324'(!g.err));
               check("puzzle_id", 324'(puzzle_id), 324'(g.pid));
               check("map", selected_map, g.map);
               check("vis", 324'(selected_visibility), 324'(g.vis));
            end
         end
      end
      if (!got) check("pulse_seen", 324'(0), 324'(1));
   endtask

   logic [80:0] alt_vis;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      for (int a = 0; a < 512; a++) rom[a] = '0;
      for (int p = 0; p < NP; p++)
         for (int j = 0; j < CELLS; j++)
            rom[p*CELLS + j] = {1'(j % 2), 1'(j % 3 == 0), 4'(((j + p + 8) % 9) + 1)};
      for (int j = 0; j < CELLS; j++) alt_vis[j] = 1'(j % 2);

      // Scenario 1: reset state and selector sequence.
      repeat (3) @(negedge clk);
      check("reset_busy", 324'(busy), 324'(0));
      check("reset_done", 324'(done), 324'(0));
      check("reset_rom_en", 324'(rom_en), 324'(0));
      check("reset_map", selected_map, 324'(0));
      check("reset_vis", 324'(selected_visibility), 324'(0));
      check("reset_pid", 324'(puzzle_id), 324'(0));
      check("reset_err", 324'(load_error), 324'(0));
      reset = 1'b1;
      check("sel_cnt_0", 324'(dut.sel_cnt), 324'(0));
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         check("sel_cnt_seq", 324'(dut.sel_cnt), 324'(i % 4));
      end

      // Scenario 2: easy load of puzzle 1.
      run_load(1, 1'b0, -1, -1, -1, 1'b0);
      check("s2_first_cell", 324'(selected_map[3:0]), 324'(1));
      check("s2_last_cell", 324'(selected_map[323:320]), 324'(9));
      check("s2_vis_alt", 324'(selected_visibility), 324'(alt_vis));

      // Scenario 3: hard load, difficulty toggled mid-load.
      run_load(1, 1'b1, 10, -1, -1, 1'b0);
      check("s3_vis_count", 324'($countones(selected_visibility)), 324'(27));

      // Scenario 4: ignored mid-load request, then a request coinciding with done.
      run_load(1, 1'b0, -1, 40, -1, 1'b1);
      run_load(-1, 1'b1, -1, -1, -1, 1'b0);

      // Scenario 5: reset in the middle of a load, fresh load afterwards.
      run_load(1, 1'b0, -1, -1, 50, 1'b0);
      repeat (8) @(negedge clk);
      run_load(-1, 1'b0, -1, -1, -1, 1'b0);

      // Scenario 6: out-of-range value in cell 10 of puzzle 1.
      rom[CELLS + 10][3:0] = 4'hA;
      run_load(1, 1'b0, -1, -1, -1, 1'b0);
`ifdef MAP_VALIDATE_EN
      check("s6_vis_zero", 324'(selected_visibility), 324'(0));
`else
      check("s6_cell10", 324'(selected_map[43:40]), 324'(4'hA));
`endif

      check("scoreboard_empty", 324'(sb.size()), 324'(0));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
